// File: rtl/regfile_wb_scheduler_if.sv
// Bundle between the write-port scheduler and its requesters / decode stage.
// The master side drives the requests; the slave side is the scheduler itself.
interface regfile_wb_scheduler_if #(
    parameter int DATA_W = 32
);
    logic              a_valid;
    logic              a_ready;
    logic [4:0]        a_reg;
    logic [DATA_W-1:0] a_data;

    logic              b_valid;
    logic              b_ready;
    logic [4:0]        b_reg;
    logic [DATA_W-1:0] b_data;

    logic              issue_valid;
    logic [4:0]        issue_reg;
    logic [31:0]       busy;

    logic              regwrite;
    logic [4:0]        write_reg;
    logic [DATA_W-1:0] write_data;

    modport master (
        output a_valid, a_reg, a_data,
        output b_valid, b_reg, b_data,
        output issue_valid, issue_reg,
        input  a_ready, b_ready, busy,
        input  regwrite, write_reg, write_data
    );

    modport slave (
        input  a_valid, a_reg, a_data,
        input  b_valid, b_reg, b_data,
        input  issue_valid, issue_reg,
        output a_ready, b_ready, busy,
        output regwrite, write_reg, write_data
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: A/B arbitration with B anti-starvation,
// registered write port and a busy scoreboard for in-flight B destinations.
module regfile_wb_scheduler #(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_scheduler_if.slave bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic              grant_a;
    logic              grant_b;
    logic              xfer_a;
    logic              xfer_b;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              regwrite_q, regwrite_d;
    logic [4:0]        write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [31:0]       busy_q, busy_d;

    // Grants are gated by rst so neither requester sees ready while in reset.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst) begin
            if (bus.a_valid && bus.b_valid) begin
                if (starve_cnt_q >= LIMIT) grant_b = 1'b1;
                else                       grant_a = 1'b1;
            end else begin
                grant_a = bus.a_valid;
                grant_b = bus.b_valid;
            end
        end
    end

    assign xfer_a = bus.a_valid && grant_a;
    assign xfer_b = bus.b_valid && grant_b;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.b_valid || xfer_b) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < LIMIT) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // x0 writes complete the handshake but never assert the write enable.
    always_comb begin
        regwrite_d   = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (xfer_a) begin
            regwrite_d   = (bus.a_reg != 5'd0);
            write_reg_d  = bus.a_reg;
            write_data_d = bus.a_data;
        end else if (xfer_b) begin
            regwrite_d   = (bus.b_reg != 5'd0);
            write_reg_d  = bus.b_reg;
            write_data_d = bus.b_data;
        end
    end

    // Clear first so a same-cycle issue to the same register re-owns it.
    always_comb begin
        busy_d = busy_q;
        if (xfer_b) busy_d[bus.b_reg] = 1'b0;
        if (bus.issue_valid) busy_d[bus.issue_reg] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= 4'd0;
            regwrite_q   <= 1'b0;
            write_reg_q  <= 5'd0;
            write_data_q <= '0;
            busy_q       <= 32'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            regwrite_q   <= regwrite_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.a_ready    = grant_a;
    assign bus.b_ready    = grant_b;
    assign bus.busy       = busy_q;
    assign bus.regwrite   = regwrite_q;
    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = write_data_q;

    a_one_grant : assert property (@(posedge clk) disable iff (!rst)
        !(bus.a_ready && bus.b_ready));

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: driver pushes hand-computed
// write-port expectations, a negedge monitor pops and compares them.
module tb_regfile_wb_scheduler;
    logic clk;
    logic rst;
    int unsigned cyc;
    int n_checks;
    int n_fail;

    typedef struct {
        int unsigned cyc;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [31:0] busy;
    } exp_t;
    exp_t q[$];

    regfile_wb_scheduler_if #(.DATA_W(32)) bus ();

    regfile_wb_scheduler #(.DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd,
                         input logic iv, input logic [4:0] ir);
        bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
        bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;
        bus.issue_valid = iv; bus.issue_reg = ir;
    endtask

    task automatic step(input string lbl,
                        input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic bv, input logic [4:0] br, input logic [31:0] bd,
                        input logic iv, input logic [4:0] ir,
                        input logic e_ar, input logic e_br,
                        input logic e_rw, input logic [4:0] e_wr, input logic [31:0] e_wd,
                        input logic [31:0] e_busy, input bit push = 1'b1);
        exp_t e;
        @(posedge clk);
        #1;
        drive(av, ar, ad, bv, br, bd, iv, ir);
        #1;
        chk({lbl, ".a_ready"}, 32'(bus.a_ready), 32'(e_ar));
        chk({lbl, ".b_ready"}, 32'(bus.b_ready), 32'(e_br));
        if (push) begin
            e.cyc = cyc + 1; e.rw = e_rw; e.wr = e_wr; e.wd = e_wd; e.busy = e_busy;
            q.push_back(e);
        end
    endtask

    // Monitor: compares the registered write port against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                chk("stale_expectation", cyc, e.cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                chk("regwrite",   32'(bus.regwrite),  32'(e.rw));
                chk("write_reg",  32'(bus.write_reg), 32'(e.wr));
                chk("write_data", bus.write_data,     e.wd);
                chk("busy",       bus.busy,           e.busy);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset held with random stimulus.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom,
                  1'($urandom), 5'($urandom));
            bus.a_valid = 1'b1;
            #1;
            chk("rst.a_ready",    32'(bus.a_ready),   0);
            chk("rst.b_ready",    32'(bus.b_ready),   0);
            chk("rst.regwrite",   32'(bus.regwrite),  0);
            chk("rst.write_reg",  32'(bus.write_reg), 0);
            chk("rst.write_data", bus.write_data,     0);
            chk("rst.busy",       bus.busy,           0);
        end
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        rst = 1'b1;

        //    lbl        av ar  ad          bv br  bd          iv ir   ar br  rw wr  wd           busy
        step("first_a",  1, 5,  32'h1234,   0, 0,  0,          0, 0,   1, 0,  1, 5,  32'h1234,    32'h0);
        step("issue4",   0, 0,  0,          0, 0,  0,          1, 4,   0, 0,  0, 5,  32'h1234,    32'h10);
        step("prio_ab",  1, 3,  32'hAA,     1, 4,  32'hBB,     0, 0,   1, 0,  1, 3,  32'hAA,      32'h10);
        step("prio_b",   0, 0,  0,          1, 4,  32'hBB,     0, 0,   0, 1,  1, 4,  32'hBB,      32'h0);
        step("idle0",    0, 0,  0,          0, 0,  0,          0, 0,   0, 0,  0, 4,  32'hBB,      32'h0);
        step("issue8",   0, 0,  0,          0, 0,  0,          1, 8,   0, 0,  0, 4,  32'hBB,      32'h100);

        // Starvation: two rounds of A granted four times, then B forced.
        for (int r = 0; r < 2; r++) begin
            logic [4:0]  breg;
            logic [31:0] bsy;
            breg = (r == 0) ? 5'd8 : 5'd12;
            bsy  = (r == 0) ? 32'h100 : 32'h0;
            for (int i = 0; i < 4; i++) begin
                step("starve_a", 1, 5'(16 + r*4 + i), 32'hA000 + 32'(r*16 + i),
                     1, breg, 32'hB000 + 32'(breg), 0, 0,
                     1, 0, 1, 5'(16 + r*4 + i), 32'hA000 + 32'(r*16 + i), bsy);
            end
            step("starve_b", 1, 5'd30, 32'hDDDD, 1, breg, 32'hB000 + 32'(breg), 0, 0,
                 0, 1, 1, breg, 32'hB000 + 32'(breg), 32'h0);
        end
        step("idle1",    0, 0,  0,          0, 0,  0,          0, 0,   0, 0,  0, 12, 32'hB00C,    32'h0);

        // Counter clears when B drops out: 3 denials, B idle, then 4 fresh denials.
        for (int i = 0; i < 3; i++)
            step("clr_a", 1, 5'd1, 32'(i), 1, 5'd13, 32'h13, 0, 0, 1, 0, 1, 1, 32'(i), 32'h0);
        step("clr_gap",  1, 1,  32'h50,     0, 0,  0,          0, 0,   1, 0,  1, 1,  32'h50,      32'h0);
        for (int i = 0; i < 4; i++)
            step("clr_b", 1, 5'd2, 32'(i), 1, 5'd13, 32'h13, 0, 0, 1, 0, 1, 2, 32'(i), 32'h0);
        step("clr_bwin", 1, 2,  32'h9,      1, 13, 32'h13,     0, 0,   0, 1,  1, 13, 32'h13,      32'h0);

        // Scoreboard.
        step("sb_iss7",  0, 0,  0,          0, 0,  0,          1, 7,   0, 0,  0, 13, 32'h13,      32'h80);
        step("sb_b7",    0, 0,  0,          1, 7,  32'h77,     0, 0,   0, 1,  1, 7,  32'h77,      32'h0);
        step("sb_iss9",  0, 0,  0,          0, 0,  0,          1, 9,   0, 0,  0, 7,  32'h77,      32'h200);
        step("sb_b9iss", 0, 0,  0,          1, 9,  32'h99,     1, 9,   0, 1,  1, 9,  32'h99,      32'h200);
        step("sb_b9",    0, 0,  0,          1, 9,  32'h9A,     0, 0,   0, 1,  1, 9,  32'h9A,      32'h0);

        // x0 handling and same-register A/B.
        step("x0_a",     1, 0,  32'hDEAD,   0, 0,  0,          0, 0,   1, 0,  0, 0,  32'hDEAD,    32'h0);
        step("x0_iss",   0, 0,  0,          0, 0,  0,          1, 0,   0, 0,  0, 0,  32'hDEAD,    32'h0);
        step("x0_b",     0, 0,  0,          1, 0,  32'hBEEF,   0, 0,   0, 1,  0, 0,  32'hBEEF,    32'h0);
        step("same_ab",  1, 3,  32'h31,     1, 3,  32'h32,     0, 0,   1, 0,  1, 3,  32'h31,      32'h0);
        step("same_b",   0, 0,  0,          1, 3,  32'h32,     0, 0,   0, 1,  1, 3,  32'h32,      32'h0);

        // Mid-operation reset with an accepted-but-unwritten B result.
        step("mr_iss2",  0, 0,  0,          0, 0,  0,          1, 2,   0, 0,  0, 3,  32'h32,      32'h4);
        step("mr_iss6",  0, 0,  0,          0, 0,  0,          1, 6,   0, 0,  0, 3,  32'h32,      32'h44);
        step("mr_b2",    0, 0,  0,          1, 2,  32'h22,     0, 0,   0, 1,  0, 0,  0,           0, 1'b0);
        @(posedge clk);
        #1;
        chk("mr_pre.regwrite",  32'(bus.regwrite),  1);
        chk("mr_pre.write_reg", 32'(bus.write_reg), 2);
        chk("mr_pre.busy",      bus.busy,           32'h40);
        drive(1, 4, 32'h44, 1, 6, 32'h66, 0, 0);
        rst = 1'b0;
        #1;
        chk("mr.regwrite",   32'(bus.regwrite),  0);
        chk("mr.write_reg",  32'(bus.write_reg), 0);
        chk("mr.write_data", bus.write_data,     0);
        chk("mr.busy",       bus.busy,           0);
        chk("mr.a_ready",    32'(bus.a_ready),   0);
        chk("mr.b_ready",    32'(bus.b_ready),   0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        rst = 1'b1;
        e.cyc = cyc; e.rw = 1'b0; e.wr = 5'd0; e.wd = 32'h0; e.busy = 32'h0;
        q.push_back(e);
        step("mr_idle1", 0, 0,  0,          0, 0,  0,          0, 0,   0, 0,  0, 0,  0,           32'h0);
        step("mr_idle2", 0, 0,  0,          0, 0,  0,          0, 0,   0, 0,  0, 0,  0,           32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
